// File: rtl/sprite_pkg.sv
// Shared sizes, FSM state type and a row bit-reversal helper for the sprite writer.
package sprite_pkg;

  localparam int SPR_ROWS = 16;
  localparam int SPR_COLS = 32;
  localparam int ROW_AW   = 4;
  localparam int COL_AW   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2
  } sprite_wr_state_t;

  // Mirrors a row left-to-right: column 0 swaps with column 31.
  function automatic logic [SPR_COLS-1:0] bit_reverse(input logic [SPR_COLS-1:0] v);
    logic [SPR_COLS-1:0] r;
    for (int i = 0; i < SPR_COLS; i++) begin
      r[i] = v[SPR_COLS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_buf.sv
// 16x32 sprite storage: one bit-enabled synchronous write port, one asynchronous read port.
module sprite_buf
  import sprite_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [ROW_AW-1:0]   wr_row,
  input  logic [SPR_COLS-1:0] wr_data,
  input  logic [SPR_COLS-1:0] wr_be,
  input  logic [ROW_AW-1:0]   rd_row,
  output logic [SPR_COLS-1:0] rd_data
);

  logic [SPR_COLS-1:0] rows [SPR_ROWS];

  // NOTE: the array has no reset on purpose; contents survive rst and are zeroed by a CLEAR.
  always_ff @(posedge clk) begin
    if (we) begin
      rows[wr_row] <= (rows[wr_row] & ~wr_be) | (wr_data & wr_be);
    end
  end

  assign rd_data = rows[rd_row];

endmodule

// File: rtl/sprite_writer.sv
// Sprite buffer controller: bulk CLEAR, ROM LOAD (optionally mirrored) and single-pixel writes.
module sprite_writer
  import sprite_pkg::*;
#(
  parameter bit FLIP_X = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_start,
  input  logic                load_start,
  output logic [ROW_AW-1:0]   rom_addr,
  input  logic [SPR_COLS-1:0] rom_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [COL_AW-1:0]   wr_x,
  input  logic [ROW_AW-1:0]   wr_y,
  input  logic                wr_bit,
  input  logic [ROW_AW-1:0]   rd_addr,
  output logic [SPR_COLS-1:0] rd_data,
  output logic                busy,
  output logic                done
);

  sprite_wr_state_t    state_q;
  logic [ROW_AW-1:0]   cnt_q;
  logic                done_q;

  logic                buf_we;
  logic [ROW_AW-1:0]   buf_row;
  logic [SPR_COLS-1:0] buf_data;
  logic [SPR_COLS-1:0] buf_be;
  logic [SPR_COLS-1:0] load_row;
  logic                last_row;

  assign load_row = FLIP_X ? bit_reverse(rom_data) : rom_data;
  assign last_row = (cnt_q == ROW_AW'(SPR_ROWS - 1));

  assign busy     = (state_q != IDLE);
  assign wr_ready = (state_q == IDLE);
  assign done     = done_q;
  assign rom_addr = (state_q == LOAD) ? cnt_q : '0;

  // Write-port mux; column x lives at bit 31-x, hence the right shift of the MSB mask.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    buf_we   = 1'b0;
    buf_row  = cnt_q;
    buf_data = '0;
    buf_be   = '1;
    unique case (state_q)
      CLEAR: buf_we = 1'b1;
      LOAD: begin
        buf_we   = 1'b1;
        buf_data = load_row;
      end
      default: begin
        buf_we   = wr_valid;
        buf_row  = wr_y;
        buf_data = {SPR_COLS{wr_bit}};
        buf_be   = {1'b1, {(SPR_COLS-1){1'b0}}} >> wr_x;
      end
    endcase
    if (rst) buf_we = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        CLEAR, LOAD: begin
          cnt_q <= cnt_q + ROW_AW'(1);
          if (last_row) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          if (clear_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end else if (load_start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  sprite_buf u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_row  (buf_row),
    .wr_data (buf_data),
    .wr_be   (buf_be),
    .rd_row  (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sprite_writer.sv
// Directed bench for sprite_writer: one unmirrored and one mirrored instance driven in lockstep.
module tb_sprite_writer;

  logic        clk = 1'b0;
  logic        rst, clear_start, load_start, wr_valid, wr_bit;
  logic [4:0]  wr_x;
  logic [3:0]  wr_y, rd_addr;
  logic [3:0]  rom_addr_a, rom_addr_b;
  logic [31:0] rom_data_a, rom_data_b, rd_data_a, rd_data_b;
  logic        wr_ready_a, wr_ready_b, busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External ROM: row r = {r, 28'h0ABCDEF}
  assign rom_data_a = {rom_addr_a, 28'h0ABCDEF};
  assign rom_data_b = {rom_addr_b, 28'h0ABCDEF};

  sprite_writer #(.FLIP_X(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .clear_start(clear_start), .load_start(load_start),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_x(wr_x), .wr_y(wr_y), .wr_bit(wr_bit),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .busy(busy_a), .done(done_a)
  );

  sprite_writer #(.FLIP_X(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .clear_start(clear_start), .load_start(load_start),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_x(wr_x), .wr_y(wr_y), .wr_bit(wr_bit),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic [4:0]  x;
    logic [3:0]  y;
    logic        b;
    logic [31:0] exp_row;
  } pix_vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } load_vec_t;

  pix_vec_t  pv [7];
  load_vec_t lv [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watches a running CLEAR/LOAD over a bounded window; drops wr_valid once idle again.
  task automatic wait_op(input string name, input bit is_load, input int exp_busy);
    int busy_n  = 0;
    int done_n  = 0;
    int done_at = -1;
    int rom_err = 0;
    int rdy_err = 0;
    int sync_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) begin
        if (rom_addr_a !== (is_load ? busy_n[3:0] : 4'd0)) rom_err++;
        busy_n++;
      end else begin
        if (rom_addr_a !== 4'd0) rom_err++;
        wr_valid = 1'b0;
      end
      if (wr_ready_a !== !busy_a) rdy_err++;
      if (busy_b !== busy_a || done_b !== done_a || rom_addr_b !== rom_addr_a) sync_err++;
      if (done_a === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      tick();
    end
    check({name, " busy cycles"}, busy_n, exp_busy);
    check({name, " done pulses"}, done_n, 1);
    check({name, " done position"}, done_at, exp_busy);
    check({name, " rom_addr errs"}, rom_err, 0);
    check({name, " wr_ready errs"}, rdy_err, 0);
    check({name, " lockstep errs"}, sync_err, 0);
  endtask

  initial begin
    pv[0] = '{5'd0,  4'd3,  1'b1, 32'h8000_0000};
    pv[1] = '{5'd31, 4'd3,  1'b1, 32'h8000_0001};
    pv[2] = '{5'd0,  4'd3,  1'b0, 32'h0000_0001};
    pv[3] = '{5'd15, 4'd7,  1'b1, 32'h0001_0000};
    pv[4] = '{5'd16, 4'd7,  1'b1, 32'h0001_8000};
    pv[5] = '{5'd31, 4'd15, 1'b1, 32'h0000_0001};
    pv[6] = '{5'd0,  4'd0,  1'b1, 32'h8000_0000};

    lv[0] = '{4'd0,  32'h00AB_CDEF, 32'hF7B3_D500};
    lv[1] = '{4'd5,  32'h50AB_CDEF, 32'hF7B3_D50A};
    lv[2] = '{4'd10, 32'hA0AB_CDEF, 32'hF7B3_D505};
    lv[3] = '{4'd15, 32'hF0AB_CDEF, 32'hF7B3_D50F};

    rst = 1'b1; clear_start = 1'b0; load_start = 1'b0;
    wr_valid = 1'b0; wr_bit = 1'b0; wr_x = '0; wr_y = '0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset busy", busy_a, 0);
    check("reset wr_ready", wr_ready_a, 1);
    check("reset done", done_a, 0);
    check("reset rom_addr", rom_addr_a, 0);

    // Clear the whole buffer
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    wait_op("clear", 1'b0, 16);
    for (int r = 0; r < 16; r++) begin
      rd_addr = r[3:0]; #1;
      check($sformatf("clear row %0d a", r), rd_data_a, 32'h0);
      check($sformatf("clear row %0d b", r), rd_data_b, 32'h0);
    end

    // Single-pixel writes
    for (int i = 0; i < 7; i++) begin
      check($sformatf("pix %0d wr_ready", i), wr_ready_a, 1);
      wr_x = pv[i].x; wr_y = pv[i].y; wr_bit = pv[i].b; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      rd_addr = pv[i].y; #1;
      check($sformatf("pix %0d row a", i), rd_data_a, pv[i].exp_row);
      check($sformatf("pix %0d row b", i), rd_data_b, pv[i].exp_row);
    end

    // Simultaneous clear_start and load_start: CLEAR wins, ROM stays untouched
    clear_start = 1'b1; load_start = 1'b1; tick();
    clear_start = 1'b0; load_start = 1'b0;
    wait_op("clear+load", 1'b0, 16);
    rd_addr = 4'd3; #1;
    check("clear+load row 3", rd_data_a, 32'h0);
    rd_addr = 4'd7; #1;
    check("clear+load row 7", rd_data_a, 32'h0);

    // load_start pulsed mid-CLEAR is ignored
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (5) tick();
    load_start = 1'b1; tick(); load_start = 1'b0;
    wait_op("load mid-clear", 1'b0, 10);

    // LOAD with a pixel write held: the start-cycle write commits, later ones are refused
    load_start = 1'b1; wr_valid = 1'b1; wr_x = 5'd0; wr_y = 4'd5; wr_bit = 1'b1;
    tick();
    load_start = 1'b0;
    wait_op("load", 1'b1, 16);
    check("post-load wr_valid dropped", wr_valid, 0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = lv[i].addr; #1;
      check($sformatf("load row %0d flip0", lv[i].addr), rd_data_a, lv[i].exp_a);
      check($sformatf("load row %0d flip1", lv[i].addr), rd_data_b, lv[i].exp_b);
    end

    // Reset after six LOAD edges; start requests and a write during rst are ignored
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    wait_op("clear2", 1'b0, 16);
    load_start = 1'b1; tick(); load_start = 1'b0;
    repeat (6) tick();
    check("mid-load rom_addr", rom_addr_a, 6);
    rst = 1'b1; clear_start = 1'b1; wr_valid = 1'b1; wr_x = 5'd31; wr_y = 4'd10; wr_bit = 1'b1;
    tick();
    rst = 1'b0; clear_start = 1'b0; wr_valid = 1'b0;
    check("abort busy", busy_a, 0);
    check("abort wr_ready", wr_ready_a, 1);
    check("abort rom_addr", rom_addr_a, 0);
    begin
      int done_n = 0;
      int busy_n = 0;
      for (int i = 0; i < 20; i++) begin
        if (done_a === 1'b1 || done_b === 1'b1) done_n++;
        if (busy_a === 1'b1 || busy_b === 1'b1) busy_n++;
        tick();
      end
      check("abort done pulses", done_n, 0);
      check("abort busy after", busy_n, 0);
    end
    for (int r = 0; r < 16; r++) begin
      logic [3:0]  r4;
      logic [31:0] exp_row;
      r4 = r[3:0];
      exp_row = (r < 6) ? {r4, 28'h0ABCDEF} : 32'h0;
      rd_addr = r4; #1;
      check($sformatf("abort row %0d", r), rd_data_a, exp_row);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
